// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with occupancy flags and FWFT option
// Status flags decode only from the registered count, so they never glitch on request inputs.
module fifo_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dato_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dato_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   cuenta,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

  generate
    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH || (FWFT != 0 && FWFT != 1))
    begin : g_bad_params
      $error("fifo_param: illegal parameters AE_THRESH=%0d AF_THRESH=%0d DEPTH=%0d FWFT=%0d",
             AE_THRESH, AF_THRESH, DEPTH, FWFT);
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign cuenta       = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & ~empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = wr_en & full;
    unf_d    = rd_en & empty;
    cnt_d    = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= dato_in;
  end

  generate
    if (FWFT == 1) begin : g_fwft
      assign dato_out = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
      end
      assign dato_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized queue-model bench for fifo_param, standard and FWFT instances
// Both instances share stimulus; expected behaviour comes from a word queue.
module tb_fifo_param;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0]   cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout0 = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .dato_in(din), .wr_en(wr_en), .rd_en(rd_en),
    .dato_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .cuenta(cnt0), .overflow(ovf0), .underflow(unf0));

  fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .dato_in(din), .wr_en(wr_en), .rd_en(rd_en),
    .dato_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .cuenta(cnt1), .overflow(ovf1), .underflow(unf1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of stored words; pop before push so a read at count 1 returns the old word.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_dout0 = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      automatic int  n  = mq.size();
      automatic bit  wa = wr_en && (n < DEPTH);
      automatic bit  ra = rd_en && (n > 0);
      m_ovf = wr_en && (n == DEPTH);
      m_unf = rd_en && (n == 0);
      if (ra) m_dout0 = mq.pop_front();
      if (wa) mq.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic int n = mq.size();
      chk("cuenta0", 32'(cnt0), n);
      chk("cuenta1", 32'(cnt1), n);
      chk("full", {30'd0, full1, full0}, (n == DEPTH) ? 32'd3 : 32'd0);
      chk("empty", {30'd0, empty1, empty0}, (n == 0) ? 32'd3 : 32'd0);
      chk("almost_full", {30'd0, af1, af0}, (n >= AF) ? 32'd3 : 32'd0);
      chk("almost_empty", {30'd0, ae1, ae0}, (n <= AE) ? 32'd3 : 32'd0);
      chk("overflow", {30'd0, ovf1, ovf0}, m_ovf ? 32'd3 : 32'd0);
      chk("underflow", {30'd0, unf1, unf0}, m_unf ? 32'd3 : 32'd0);
      chk("dato_out_std", 32'(dout0), 32'(m_dout0));
      if (n > 0) chk("dato_out_fwft", 32'(dout1), 32'(mq[0]));
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cuenta", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_almost_empty", 32'(ae0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_almost_full", 32'(af0), 0);
    chk("rst_dato_out", 32'(dout0), 0);
    chk("rst_pulses", {30'd0, ovf0, unf0}, 0);
    rst = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      if (i == 13) chk("af_at_13", 32'(af0), 0);
      if (i == 14) chk("af_at_14", 32'(af0), 1);
      if (i == 15) chk("full_at_15", 32'(full0), 0);
    end
    chk("fill_cuenta", 32'(cnt0), 16);
    chk("fill_full", 32'(full0), 1);
    cyc(1'b1, 1'b0, 16'hFFFF);
    chk("ovf_pulse", 32'(ovf0), 1);
    chk("ovf_cuenta", 32'(cnt0), 16);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_clears", 32'(ovf0), 0);

    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("drain_data", 32'(dout0), i);
    end
    chk("drain_empty", 32'(empty0), 1);
    cyc(1'b0, 1'b1, '0);
    chk("unf_pulse", 32'(unf0), 1);
    chk("unf_hold_data", 32'(dout0), 32'h10);
    cyc(1'b0, 1'b0, '0);
    chk("unf_clears", 32'(unf0), 0);

    cyc(1'b1, 1'b1, 16'h1234);
    chk("both_empty_unf", 32'(unf0), 1);
    chk("both_empty_cuenta", 32'(cnt0), 1);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, DW'($urandom));
    cyc(1'b1, 1'b1, 16'hBEEF);
    chk("both_full_ovf", 32'(ovf0), 1);
    chk("both_full_cuenta", 32'(cnt0), 15);
    chk("both_full_data", 32'(dout0), 32'h1234);
    while (!empty0) cyc(1'b0, 1'b1, '0);

    cyc(1'b1, 1'b0, 16'hA5A5);
    chk("fwft_not_empty", 32'(empty1), 0);
    chk("fwft_head", 32'(dout1), 32'hA5A5);
    cyc(1'b0, 1'b1, '0);
    chk("fwft_pop_empty", 32'(empty1), 1);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(16'h0100 + i));
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, DW'(16'h0200 + i));
    chk("steady_cuenta", 32'(cnt0), 8);
    chk("steady_order", 32'(dout0), 32'h0200 + 31);

    for (int i = 0; i < 2000; i++) begin
      automatic int ph = (i / 250) % 3;
      automatic int pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      cyc($urandom_range(99) < pw, $urandom_range(99) < (100 - pw), DW'($urandom));
    end

    while (empty0) cyc(1'b1, 1'b0, DW'($urandom));
    while (cnt0 < 9) cyc(1'b1, 1'b0, DW'($urandom));
    while (cnt0 > 9) cyc(1'b0, 1'b1, '0);
    wr_en = 1'b1;
    din = 16'h5555;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cuenta", 32'(cnt0), 0);
    chk("async_rst_flags", {28'd0, empty0, ae0, full0, af0}, 32'b1100);
    chk("async_rst_data", 32'(dout0), 0);
    chk("async_rst_pulses", {30'd0, ovf0, unf0}, 0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 16'h7777);
    chk("post_rst_cuenta", 32'(cnt0), 1);
    chk("post_rst_fwft", 32'(dout1), 32'h7777);
    cyc(1'b0, 1'b1, '0);
    chk("post_rst_read", 32'(dout0), 32'h7777);
    chk("post_rst_empty", 32'(empty0), 1);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning log2 of depth (DEPTH = 2**ADDR_W = 16).
REQ-003 The block SHALL have parameter AF_THRESH, default 14, meaning almost_full level; legal range AE_THRESH < AF_THRESH <= DEPTH.
REQ-004 The block SHALL have parameter AE_THRESH, default 2, meaning almost_empty level; legal range 0 <= AE_THRESH < AF_THRESH.
REQ-005 The block SHALL have parameter FWFT, default 0, meaning 0 = standard read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 dato_in  input  DATA_W  write data.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request.
REQ-011 dato_out  output  DATA_W  read data.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_THRESH.
REQ-015 almost_empty  output  1  count <= AE_THRESH.
REQ-016 cuenta  output  ADDR_W+1  words stored, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse: write rejected.
REQ-018 underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 Storage SHALL be a DEPTH x DATA_W array with ADDR_W-bit wr_ptr/rd_ptr, wrapping from DEPTH-1 to 0 naturally.
REQ-020 A write SHALL be accepted when wr_en=1 and full=0: mem[wr_ptr]<=dato_in, wr_ptr+1.
REQ-021 A read SHALL be accepted when rd_en=1 and empty=0: rd_ptr+1.
REQ-022 wr_en=1 with full=1 SHALL be rejected even if rd_en=1 that cycle; no storage/pointer change; overflow=1 the following cycle.
REQ-023 rd_en=1 with empty=1 SHALL be rejected even if wr_en=1 that cycle; underflow=1 the following cycle.
REQ-024 cuenta SHALL update on the edge: +1 write-only accepted, -1 read-only accepted, unchanged when both or neither accepted.
REQ-025 full, empty, almost_full, almost_empty SHALL be decoded from the cuenta register only (valid the cycle after the causing edge, no glitch from inputs).
REQ-026 FWFT=0: on accepted read, dato_out SHALL load mem[rd_ptr] at that edge (1-cycle latency) and hold otherwise.
REQ-027 FWFT=1: dato_out SHALL equal mem[rd_ptr] whenever empty=0 (head word visible, rd_en acknowledges/pops); value when empty=1 is don't-care.
REQ-028 Write to empty FIFO: empty SHALL deassert the cycle after the write edge; in FWFT=1 the word is on dato_out that same cycle.
REQ-029 Simultaneous accepted read/write with cuenta=1 SHALL return the old word and keep the new one (no bypass, no loss).
REQ-030 overflow/underflow SHALL be single-cycle pulses, re-asserting each cycle a rejection repeats.
REQ-031 Illegal parameter combinations SHALL halt elaboration/simulation with an error.

Reset
REQ-032 rst=1 SHALL immediately, without clk: pointers=0, cuenta=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dato_out=0 (FWFT=0).
REQ-033 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard all stored words.
REQ-034 Requests in the first edge after rst deasserts SHALL be honoured normally.

Verification
REQ-035 Reset then write 0x0001..0x0010 (16 words) -> almost_full after 14th, full after 16th, cuenta=16; 17th write 0xFFFF -> overflow pulse, cuenta stays 16.
REQ-036 Read 16 from full (FWFT=0) -> dato_out 0x0001..0x0010 each one cycle after rd_en; empty after last; extra read -> underflow pulse, dato_out holds 0x0010.
REQ-037 FWFT=1, write 0xA5A5 to empty -> next cycle empty=0, dato_out=0xA5A5 with no rd_en; rd_en one cycle -> empty=1.
REQ-038 cuenta=8, wr_en=rd_en=1 for 40 cycles with incrementing data -> cuenta stays 8, pointers wrap, output order matches input order.
REQ-039 Full FIFO, wr_en=rd_en=1 -> read accepted, write rejected, overflow=1, cuenta=15; empty FIFO, both -> write accepted, underflow=1, cuenta=1.
REQ-040 Assert rst asynchronously mid-burst with cuenta=9 -> outputs at reset values before next clk edge; post-reset write/read returns new data only.
